// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants for the sequential divider
package alu_pkg;

   localparam int ALU_W      = 16;
   localparam int ITER_CNT_W = 4;

   localparam logic [ALU_W-1:0] DIVZ_QUOT_DEF = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

`ifdef DIV_SIGNED_EN
   // Two's complement negate when s is set; 0x8000 maps onto itself.
   function automatic logic [ALU_W-1:0] neg_if(input logic [ALU_W-1:0] v, input logic s);
      return s ? (~v + 1'b1) : v;
   endfunction
`endif

endpackage

// File: rtl/Subtractor_16bit.sv
// rtl/Subtractor_16bit.sv - 16-bit ripple-borrow subtractor, diff = a - b - bin
module Subtractor_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        bin,
   output logic [15:0] diff,
   output logic        bout
);

   logic [16:0] borrow;

   always_comb begin
      borrow[0] = bin;
      for (int i = 0; i < 16; i++) begin
         diff[i]       = a[i] ^ b[i] ^ borrow[i];
         borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
      end
   end

   assign bout = borrow[16];

endmodule

// File: rtl/div_16bit_seq.sv
// rtl/div_16bit_seq.sv - sequential restoring divider, one quotient bit per cycle
// Optional signed operands with DIV_SIGNED_EN.
module div_16bit_seq
   import alu_pkg::*;
#(
   parameter int               WIDTH     = ALU_W,
   parameter logic [WIDTH-1:0] DIVZ_QUOT = DIVZ_QUOT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_t            state;
   logic [WIDTH-1:0]      q;
   logic [WIDTH-1:0]      r;
   logic [WIDTH-1:0]      d;
   logic [ITER_CNT_W-1:0] cnt;

   logic [WIDTH-1:0] rs;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             msb;
   logic             qbit;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] a_cap;
   logic [WIDTH-1:0] b_cap;

`ifdef DIV_SIGNED_EN
   logic sq;
   logic sr;

   assign a_cap = neg_if(dividend, dividend[WIDTH-1]);
   assign b_cap = neg_if(divisor, divisor[WIDTH-1]);
`else
   assign a_cap = dividend;
   assign b_cap = divisor;
`endif

   // msb is the 17th bit of the shifted partial remainder; when set, Rs >= D always.
   assign msb    = r[WIDTH-1];
   assign rs     = {r[WIDTH-2:0], q[WIDTH-1]};
   assign qbit   = msb | ~bout;
   assign r_next = qbit ? diff : rs;
   assign q_next = {q[WIDTH-2:0], qbit};

   Subtractor_16bit u_sub (
      .a    (rs),
      .b    (d),
      .bin  (1'b0),
      .diff (diff),
      .bout (bout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         cnt         <= '0;
         q           <= '0;
         r           <= '0;
         d           <= '0;
`ifdef DIV_SIGNED_EN
         sq          <= 1'b0;
         sr          <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               // Nothing toggles here without start so the clock can be gated off.
               if (start) begin
                  q    <= a_cap;
                  r    <= '0;
                  d    <= b_cap;
                  cnt  <= '0;
                  busy <= 1'b1;
`ifdef DIV_SIGNED_EN
                  sq   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  sr   <= dividend[WIDTH-1];
`endif
                  if (divisor == '0) begin
                     state       <= DONE;
                     done        <= 1'b1;
                     quotient    <= DIVZ_QUOT;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= CALC;
                  end
               end
            end

            CALC: begin
               q   <= q_next;
               r   <= r_next;
               cnt <= cnt + 1'b1;
               if (cnt == {ITER_CNT_W{1'b1}}) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
                  quotient    <= neg_if(q_next, sq);
                  remainder   <= neg_if(r_next, sr);
`else
                  quotient    <= q_next;
                  remainder   <= r_next;
`endif
               end
            end

            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
